// File: rtl/i2c_pkg.sv
// ============================================================================
// Module   : i2c_pkg
// Brief    : Shared FSM states, quarter-index encoding and default target
//            address for the single-byte I2C write controller.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_ADDR  = 3'd2,
    ST_ACK1  = 3'd3,
    ST_DATA  = 3'd4,
    ST_ACK2  = 3'd5,
    ST_STOP  = 3'd6
  } state_t;

  // Quarter index inside one bit slot: q0/q1 SCL low, q2/q3 SCL high
  localparam logic [1:0] c_Q0 = 2'd0;
  localparam logic [1:0] c_Q1 = 2'd1;
  localparam logic [1:0] c_Q2 = 2'd2;
  localparam logic [1:0] c_Q3 = 2'd3;

  localparam logic [6:0] c_DEFAULT_ADDR = 7'h2A;

endpackage

`default_nettype wire

// File: rtl/i2c_quarter_tick.sv
// ============================================================================
// Module   : i2c_quarter_tick
// Brief    : DIV-cycle quarter counter with 2-bit quarter index; runs only
//            while enabled and holds its count while stall is high.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module i2c_quarter_tick #(
  parameter int DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       stall,
  output logic       tick,
  output logic [1:0] q
);

  localparam int c_CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(DIV - 1);

  logic [c_CW-1:0] r_cnt;
  logic [1:0]      r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_q   <= '0;
    end else if (!en) begin
      r_cnt <= '0;
      r_q   <= '0;
    end else if (!stall) begin
      if (r_cnt == c_LAST) begin
        r_cnt <= '0;
        r_q   <= r_q + 2'd1;
      end else begin
        r_cnt <= r_cnt + c_CW'(1);
      end
    end
  end

  assign tick = en && !stall && (r_cnt == c_LAST);
  assign q    = r_q;

endmodule

`default_nettype wire

// File: rtl/i2c_controller_write.sv
// ============================================================================
// Module   : i2c_controller_write
// Brief    : Single-byte I2C write master: START, addr+W, ACK, data, ACK, STOP.
//            Define I2C_CLK_STRETCH_EN to honour target clock stretching.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module i2c_controller_write
  import i2c_pkg::*;
#(
  parameter int DIV    = 4,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [7:0]        req_data,
  output logic              busy,
  output logic              done,
  output logic              nack,
  inout  wire               i2c_scl,
  inout  wire               i2c_sda
);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_shift;
  logic [7:0] r_data;
  logic       r_ack_bit;
  logic       r_nack;
  logic       r_done;
  logic       w_scl_low;
  logic       w_sda_low;
  logic       w_tick;
  logic [1:0] w_q;
  logic       w_stall;
  logic       w_busy;
  logic       w_slot_end;

  assign w_busy     = (r_state != ST_IDLE);
  assign w_slot_end = w_tick && (w_q == c_Q3);

`ifdef I2C_CLK_STRETCH_EN
  // SCL is released for all of q2; a target holding it low freezes the count
  assign w_stall = w_busy && (w_q == c_Q2) && !i2c_scl;
`else
  assign w_stall = 1'b0;
`endif

  i2c_quarter_tick #(
    .DIV (DIV)
  ) u_quarter_tick (
    .clk   (clk),
    .rst   (rst),
    .en    (w_busy),
    .stall (w_stall),
    .tick  (w_tick),
    .q     (w_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_scl_low   = 1'b0;
    w_sda_low   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) w_state_nxt = ST_START;
      end
      ST_START: begin
        w_sda_low = (w_q == c_Q2) || (w_q == c_Q3);
        if (w_slot_end) w_state_nxt = ST_ADDR;
      end
      ST_ADDR, ST_DATA: begin
        w_scl_low = (w_q == c_Q0) || (w_q == c_Q1);
        w_sda_low = !r_shift[7];
        if (w_slot_end && (r_bit_cnt == 3'd7))
          w_state_nxt = (r_state == ST_ADDR) ? ST_ACK1 : ST_ACK2;
      end
      ST_ACK1: begin
        w_scl_low = (w_q == c_Q0) || (w_q == c_Q1);
        if (w_slot_end) w_state_nxt = r_ack_bit ? ST_STOP : ST_DATA;
      end
      ST_ACK2: begin
        w_scl_low = (w_q == c_Q0) || (w_q == c_Q1);
        if (w_slot_end) w_state_nxt = ST_STOP;
      end
      ST_STOP: begin
        w_scl_low = (w_q == c_Q0);
        w_sda_low = (w_q == c_Q0) || (w_q == c_Q1);
        if (w_slot_end) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_ack_bit <= 1'b0;
      r_nack    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_shift   <= {req_addr, 1'b0};
            r_data    <= req_data;
            r_bit_cnt <= '0;
            r_nack    <= 1'b0;
          end
        end
        ST_ADDR, ST_DATA: begin
          // bit counter wraps 7 -> 0, ready for the next byte
          if (w_slot_end) begin
            r_shift   <= {r_shift[6:0], 1'b0};
            r_bit_cnt <= r_bit_cnt + 3'd1;
          end
        end
        ST_ACK1, ST_ACK2: begin
          if (w_tick && (w_q == c_Q2)) r_ack_bit <= i2c_sda;
          if (w_slot_end) begin
            if (r_ack_bit)                r_nack  <= 1'b1;
            else if (r_state == ST_ACK1)  r_shift <= r_data;
          end
        end
        ST_STOP: begin
          if (w_slot_end) r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign i2c_scl   = w_scl_low ? 1'b0 : 1'bz;
  assign i2c_sda   = w_sda_low ? 1'b0 : 1'bz;
  assign req_ready = !w_busy;
  assign busy      = w_busy;
  assign done      = r_done;
  assign nack      = r_nack;

endmodule

`default_nettype wire

// File: tb/tb_i2c_controller_write.sv
// ============================================================================
// Module   : tb_i2c_controller_write
// Brief    : Self-checking bench: bus monitor/target model plus scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_i2c_controller_write;
  import i2c_pkg::*;

  localparam int DIV  = 4;
  localparam int SLOT = 4 * DIV;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [6:0] req_addr;
  logic [7:0] req_data;
  logic       busy;
  logic       done;
  logic       nack;
  wire        i2c_scl;
  wire        i2c_sda;

  logic tb_scl_low = 1'b0;
  logic tb_sda_low = 1'b0;
  logic tb_data_ack;

  pullup (i2c_scl);
  pullup (i2c_sda);
  assign i2c_scl = tb_scl_low ? 1'b0 : 1'bz;
  assign i2c_sda = tb_sda_low ? 1'b0 : 1'bz;

  i2c_controller_write #(
    .DIV    (DIV),
    .ADDR_W (7)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .busy      (busy),
    .done      (done),
    .nack      (nack),
    .i2c_scl   (i2c_scl),
    .i2c_sda   (i2c_sda)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] b0;
    logic [7:0] b1;
    logic       nack;
    int         lat;
    int         rises;
  } exp_t;

  typedef struct {
    logic [6:0] addr;
    logic [7:0] data;
    logic       data_ack;
    logic       exp_nack;
    int         exp_slots;
    int         exp_rises;
  } vec_t;

  exp_t sb_q[$];
  int   acc_q[$];
  int   n_acc = 0;
  int   n_done = 0;
  int   last_acc_edge = 0;
  int   last_done_edge = 0;

  // Bus monitor / target model state
  logic       prev_scl = 1'b1;
  logic       prev_sda = 1'b1;
  logic       prev_done = 1'b0;
  logic       chk_after_acc = 1'b0;
  logic       addr_acked = 1'b0;
  int         mon_rises = 0;
  logic [7:0] mon_sh = '0;
  logic [7:0] mon_byte0 = '0;
  logic [7:0] mon_byte1 = '0;

  always @(negedge clk) begin
    exp_t e;
    int   a;
    if (rst) begin
      sb_q.delete();
      acc_q.delete();
      tb_sda_low    = 1'b0;
      prev_scl      = 1'b1;
      prev_sda      = 1'b1;
      prev_done     = 1'b0;
      chk_after_acc = 1'b0;
      mon_rises     = 0;
      addr_acked    = 1'b0;
    end else begin
      if (prev_scl && i2c_scl && prev_sda && !i2c_sda) begin
        mon_rises  = 0;
        addr_acked = 1'b0;
      end
      if (!prev_scl && i2c_scl) begin
        mon_sh = {mon_sh[6:0], i2c_sda};
        mon_rises++;
        if (mon_rises == 8)  mon_byte0 = mon_sh;
        if (mon_rises == 17) mon_byte1 = mon_sh;
      end
      if (prev_scl && !i2c_scl) begin
        if (mon_rises == 8 && mon_byte0 == {c_DEFAULT_ADDR, 1'b0}) begin
          tb_sda_low = 1'b1;
          addr_acked = 1'b1;
        end
        if (mon_rises == 9)  tb_sda_low = 1'b0;
        if (mon_rises == 17 && addr_acked && tb_data_ack) tb_sda_low = 1'b1;
        if (mon_rises == 18) tb_sda_low = 1'b0;
      end
      prev_scl = i2c_scl;
      prev_sda = i2c_sda;

      if (chk_after_acc) begin
        check("acc_busy", busy, 1);
        check("acc_ready", req_ready, 0);
        check("acc_nack_clr", nack, 0);
        chk_after_acc = 1'b0;
      end
      if (prev_done) check("done_width", done, 0);
      if (done) begin
        n_done++;
        last_done_edge = cyc;
        if (sb_q.size() == 0 || acc_q.size() == 0) begin
          check("sb_empty_at_done", sb_q.size(), 1);
        end else begin
          e = sb_q.pop_front();
          a = acc_q.pop_front();
          check("latency", cyc - a, e.lat);
          check("nack", nack, e.nack);
          check("addr_byte", mon_byte0, e.b0);
          if (e.rises == 19) check("data_byte", mon_byte1, e.b1);
          check("scl_rises", mon_rises, e.rises);
          check("done_ready", req_ready, 1);
          check("done_busy", busy, 0);
        end
      end
      prev_done = done;
      if (req_valid && req_ready) begin
        acc_q.push_back(cyc + 1);
        last_acc_edge = cyc + 1;
        n_acc++;
        chk_after_acc = 1'b1;
      end
    end
  end

  task automatic push_exp(input logic [6:0] a, input logic [7:0] d, input logic nk,
                          input int lat, input int rises);
    exp_t e;
    e.b0 = {a, 1'b0};
    e.b1 = d;
    e.nack = nk;
    e.lat = lat;
    e.rises = rises;
    sb_q.push_back(e);
  endtask

  task automatic wait_acc(input string name);
    int start;
    start = n_acc;
    for (int k = 0; k < 500; k++) begin
      @(posedge clk); #1;
      if (n_acc != start) break;
    end
    check(name, n_acc - start, 1);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk); #1;
      if (sb_q.size() == 0) break;
    end
    check("sb_drained", sb_q.size(), 0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [6:0] a, input logic [7:0] d, input logic nk,
                      input int lat, input int rises);
    push_exp(a, d, nk, lat, rises);
    req_addr  = a;
    req_data  = d;
    req_valid = 1'b1;
    wait_acc("accept");
    // Changing the request after accept must not affect the bus
    req_valid = 1'b0;
    req_addr  = ~a;
    req_data  = ~d;
  endtask

  vec_t tbl[6];
  int   done_before;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{7'h2A, 8'hA5, 1'b1, 1'b0, 20, 19};
    tbl[1] = '{7'h15, 8'h3C, 1'b1, 1'b1, 11, 10};
    tbl[2] = '{7'h2A, 8'h0F, 1'b0, 1'b1, 20, 19};
    tbl[3] = '{7'h2A, 8'h00, 1'b1, 1'b0, 20, 19};
    tbl[4] = '{7'h7F, 8'hFF, 1'b1, 1'b1, 11, 10};
    tbl[5] = '{7'h2A, 8'hFF, 1'b0, 1'b1, 20, 19};

    rst         = 1'b1;
    req_valid   = 1'b0;
    req_addr    = '0;
    req_data    = '0;
    tb_data_ack = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_nack", nack, 0);
    check("rst_scl", i2c_scl, 1);
    check("rst_sda", i2c_sda, 1);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) begin
      tb_data_ack = tbl[i].data_ack;
      send(tbl[i].addr, tbl[i].data, tbl[i].exp_nack,
           tbl[i].exp_slots * SLOT, tbl[i].exp_rises);
      wait_idle();
      check("nack_status", nack, tbl[i].exp_nack);
    end

    // req_valid held across done: second request only once idle again
    tb_data_ack = 1'b1;
    push_exp(7'h2A, 8'h11, 1'b0, 20 * SLOT, 19);
    push_exp(7'h2A, 8'h22, 1'b0, 20 * SLOT, 19);
    req_addr  = 7'h2A;
    req_data  = 8'h11;
    req_valid = 1'b1;
    wait_acc("b2b_first");
    req_data = 8'h22;
    wait_acc("b2b_second");
    check("b2b_gap", last_acc_edge - last_done_edge, 1);
    req_valid = 1'b0;
    wait_idle();

    // Reset in the middle of data bit 3 (SCL and SDA both driven low there)
    req_addr  = 7'h2A;
    req_data  = 8'hA5;
    req_valid = 1'b1;
    wait_acc("rst_mid_accept");
    req_valid = 1'b0;
    repeat (14 * SLOT + 6 - 1) @(posedge clk);
    #3;
    check("pre_rst_scl", i2c_scl, 0);
    rst = 1'b1;
    #1;
    check("mid_rst_scl", i2c_scl, 1);
    check("mid_rst_sda", i2c_sda, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", req_ready, 1);
    done_before = n_done;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (22 * SLOT) @(posedge clk);
    #1;
    check("mid_rst_no_done", n_done - done_before, 0);
    check("mid_rst_idle_sda", i2c_sda, 1);

    send(7'h2A, 8'h5A, 1'b0, 20 * SLOT, 19);
    wait_idle();

`ifdef I2C_CLK_STRETCH_EN
    // Target holds SCL low for 10 clk into q2 of the first address bit
    send(7'h2A, 8'hC3, 1'b0, 20 * SLOT + 10, 19);
    repeat (20 - 1) @(posedge clk);
    #1;
    tb_scl_low = 1'b1;
    repeat (14) @(posedge clk);
    #1;
    tb_scl_low = 1'b0;
    wait_idle();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
